// File: rtl/alu_pipe_nbit_pkg.sv
// alu_pipe_nbit_pkg: opcodes, widths and flag bundle shared by the pipelined ALU (package alu_pkg)
package alu_pkg;
  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_INC = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_LAST_VALID = 4'd9;
  typedef struct packed {
    logic carry_out;
    logic borrow;
    logic zero;
    logic parity;
    logic invalid_op;
  } alu_flags_t;
endpackage

// File: rtl/alu_pipe_nbit_if.sv
// alu_pipe_nbit_if: operand/result handshake bundle; ALU_OVERFLOW_EN adds the overflow flag
interface alu_pipe_nbit_if #(
  parameter int BUS_WIDTH = 16,
  parameter int ERR_CNT_WIDTH = 8
);
  import alu_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic carry_in;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic out_valid;
  logic out_ready;
  logic [BUS_WIDTH-1:0] y;
  logic carry_out;
  logic borrow;
  logic zero;
  logic parity;
  logic invalid_op;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
`ifdef ALU_OVERFLOW_EN
  logic overflow;
`endif
  modport master (
    output in_valid, a, b, carry_in, opcode, out_ready,
    input in_ready, out_valid, y, carry_out, borrow, zero, parity, invalid_op, err_cnt
`ifdef ALU_OVERFLOW_EN
    , overflow
`endif
  );
  modport slave (
    input in_valid, a, b, carry_in, opcode, out_ready,
    output in_ready, out_valid, y, carry_out, borrow, zero, parity, invalid_op, err_cnt
`ifdef ALU_OVERFLOW_EN
    , overflow
`endif
  );
endinterface

// File: rtl/alu_pipe_nbit_core_comb.sv
// alu_core_comb: combinational opcode decode, result and flags; ALU_OVERFLOW_EN adds signed overflow
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic carry_in,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [BUS_WIDTH-1:0] y,
  output alu_flags_t flags
`ifdef ALU_OVERFLOW_EN
  , output logic overflow
`endif
);
  localparam int M = BUS_WIDTH - 1;
  localparam logic [BUS_WIDTH:0] ONE = {{BUS_WIDTH{1'b0}}, 1'b1};
  logic [BUS_WIDTH:0] sum, dif, inc, dec;
  logic co, bo;
  // the extra top bit of each extended op is the carry (add) or borrow (subtract)
  assign sum = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
  assign dif = {1'b0, a} - {1'b0, b};
  assign inc = {1'b0, a} + ONE;
  assign dec = {1'b0, a} - ONE;
  always_comb begin
    y = '0;
    co = 1'b0;
    bo = 1'b0;
    case (opcode)
      OP_ADD: {co, y} = sum;
      OP_SUB: {bo, y} = dif;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: {co, y} = {a, 1'b0};
      OP_SHR: {y, co} = {1'b0, a};
      OP_INC: {co, y} = inc;
      OP_DEC: {bo, y} = dec;
      default: ;
    endcase
  end
  assign flags = '{carry_out: co, borrow: bo, zero: ~|y, parity: ^y,
                   invalid_op: opcode > OP_LAST_VALID};
`ifdef ALU_OVERFLOW_EN
  assign overflow = (opcode == OP_ADD) ? (a[M] == b[M]) && (y[M] != a[M]) :
                    (opcode == OP_SUB) ? (a[M] != b[M]) && (y[M] != a[M]) :
                    (opcode == OP_INC) ? ~a[M] & y[M] :
                    (opcode == OP_DEC) ? a[M] & ~y[M] : 1'b0;
`endif
endmodule

// File: rtl/alu_pipe_nbit.sv
// alu_pipe_nbit: 2-stage valid/ready pipelined N-bit ALU with saturating invalid-op counter;
// define ALU_OVERFLOW_EN to add a registered signed-overflow flag
module alu_pipe_nbit
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  alu_pipe_nbit_if.slave bus
);
  logic s1_v, s2_v, s1_cin, s2_load, in_ready, accept;
  logic [BUS_WIDTH-1:0] s1_a, s1_b, c_y, s2_y;
  logic [OPCODE_WIDTH-1:0] s1_op;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  alu_flags_t c_flags, s2_flags;
`ifdef ALU_OVERFLOW_EN
  logic c_ov, s2_ov;
`endif
  // in_ready is exactly "S1 can load": empty, or its beat moves into S2 this cycle
  assign s2_load = ~s2_v | bus.out_ready;
  assign in_ready = ~s1_v | s2_load;
  assign accept = bus.in_valid & in_ready;
  alu_core_comb #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .a(s1_a),
    .b(s1_b),
    .carry_in(s1_cin),
    .opcode(s1_op),
    .y(c_y),
    .flags(c_flags)
`ifdef ALU_OVERFLOW_EN
    , .overflow(c_ov)
`endif
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_cin <= 1'b0;
      s1_op <= '0;
    end else if (in_ready) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a <= bus.a;
        s1_b <= bus.b;
        s1_cin <= bus.carry_in;
        s1_op <= bus.opcode;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_y <= '0;
      s2_flags <= '0;
`ifdef ALU_OVERFLOW_EN
      s2_ov <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_y <= c_y;
        s2_flags <= c_flags;
`ifdef ALU_OVERFLOW_EN
        s2_ov <= c_ov;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (accept && bus.opcode > OP_LAST_VALID && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = s2_v;
  assign bus.y = s2_y;
  assign bus.carry_out = s2_flags.carry_out;
  assign bus.borrow = s2_flags.borrow;
  assign bus.zero = s2_flags.zero;
  assign bus.parity = s2_flags.parity;
  assign bus.invalid_op = s2_flags.invalid_op;
  assign bus.err_cnt = err_cnt;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflow = s2_ov;
`endif
endmodule

// File: doc/alu_pipe_nbit.md
Name: alu_pipe_nbit

Overview:
- Parametrised, pipelined successor to the team's combinational N-bit ALU.
- Same opcode set and flag semantics, registered through a 2-stage pipeline with valid/ready handshakes on input and output.
- Adds a saturating invalid-opcode counter.
- Sits between an operand issue stage and a result writeback/consumer that may apply backpressure.

Parameters:
- BUS_WIDTH, 16, operand/result width in bits (>=4).
- ERR_CNT_WIDTH, 8, width of the saturating invalid-op counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  BUS_WIDTH  operand A.
- b  input  BUS_WIDTH  operand B.
- carry_in  input  1  carry into ADD.
- opcode  input  4  operation select.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- y  output  BUS_WIDTH  result.
- carry_out  output  1  ADD/SHL/INC carry.
- borrow  output  1  SUB/DEC borrow.
- zero  output  1  y == 0.
- parity  output  1  XOR-reduce of y (1 = odd).
- invalid_op  output  1  opcode >= 10 for this beat.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of accepted invalid beats.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0; stage valids 0; err_cnt 0. Reset mid-operation discards in-flight beats with no output.
- Opcodes:
  - 0 ADD: {carry_out,y} = a+b+carry_in.
  - 1 SUB: y = a-b; borrow = (a<b).
  - 2 AND. 3 OR. 4 XOR.
  - 5 NOT: y = ~a.
  - 6 SHL: y = a<<1; carry_out = a[MSB].
  - 7 SHR: y = a>>1 logical; carry_out = a[0].
  - 8 INC: {carry_out,y} = a+1.
  - 9 DEC: y = a-1; borrow = (a==0).
  - 10-15: y = 0, invalid_op = 1, zero = 1, parity = 0.
- carry_out and borrow are 0 for any opcode not listed as driving them. Arithmetic is modulo 2^BUS_WIDTH; the carry is bit BUS_WIDTH of the extended sum.
- Pipeline:
  - S1 captures operands on an input handshake (in_valid & in_ready).
  - S2 holds the computed result and flags; S2 drives the outputs directly, all registered.
- Latency: exactly 2 cycles from accept to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Backpressure:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 loads when S1 is empty or S1 is advancing.
  - in_ready = ~s1_v | ~s2_v | out_ready (combinational, no input-to-input loop).
- Handshake rules:
  - out_valid stays high with y and flags stable until out_ready.
  - in_valid ignored when in_ready = 0.
  - No beat is dropped or duplicated.
- Simultaneous events: with pipe full and out_ready = 1, the output retires, S1 moves to S2, and a new input is accepted in the same cycle.
- err_cnt:
  - Increments when an invalid beat is accepted at input.
  - Saturates at all-ones with no wrap.
  - Simultaneous increment with saturation keeps all-ones.

Optional Feature:
- ALU_OVERFLOW_EN:
  - When defined, adds an output port overflow (1 bit), registered with the other flags.
  - overflow = signed two's-complement overflow for ADD/SUB/INC/DEC, 0 otherwise.
  - When undefined, the port and its logic are absent.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_DEC, OP_LAST_VALID = 9;
  - opcode width 4;
  - a flag-bundle struct {carry_out, borrow, zero, parity, invalid_op}.
- Sub-module alu_core_comb (parametrised BUS_WIDTH) does the pure combinational opcode decode and flag computation, instantiated between S1 and S2.

Test Plan:
- Streaming, out_ready=1: a=0xFFFF, b=0x0001, cin=0, op=0 -> 2 cycles later y=0x0000, carry_out=1, zero=1, parity=0.
- SUB borrow: a=3, b=5, op=1 -> y=0xFFFE, borrow=1, parity=1, zero=0; then DEC a=0 -> y=0xFFFF, borrow=1.
- Backpressure: issue 4 beats (ADD 1+1, 2+2, 3+3, 4+4), hold out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepted; out_valid/y=2 stable.
  - On release, results 2, 4, 6, 8 appear in order, one per cycle.
- Invalid ops: 300 beats with op=12, ERR_CNT_WIDTH=8 -> each y=0, invalid_op=1, zero=1; err_cnt saturates at 255.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight -> out_valid, y, flags, err_cnt go 0 immediately; no stale beat after release.
- With ALU_OVERFLOW_EN: ADD 0x7FFF+0x0001 -> y=0x8000, overflow=1, carry_out=0.
